// File: rtl/fifosync.sv
// fifosync: single-clock FIFO with a registered occupancy count and sticky overflow/underflow flags.
// Latency: an accepted pop shows on rd_data one cycle later; FIFOSYNC_FWFT_EN shows the head combinationally.
// Backpressure: writes are dropped while full (overflow), pops are ignored while empty (underflow).
module fifosync #(
    parameter int DW     = 16,
    parameter int AW     = 4,
    parameter int AFULL  = (1 << AW) - 1,
    parameter int AEMPTY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come only from the count register, so enables never reach them combinationally.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ONE;
            end
            if (wr_acc && !rd_acc) begin
                count <= count + ONE;
            end else if (rd_acc && !wr_acc) begin
                count <= count - ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFOSYNC_FWFT_EN
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_acc) begin
            rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_fifosync.sv
// Directed scoreboard bench for fifosync at DW=16, AW=2 (DEPTH=4), AFULL=3, AEMPTY=1.
module tb_fifosync;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;

    fifosync #(.DW(16), .AW(2), .AFULL(3), .AEMPTY(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] mq[$];
    int          mcount = 0;
    bit          movf = 1'b0;
    bit          mudf = 1'b0;
    logic [15:0] last_rd = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        logic [15:0] exp_rd;
`ifdef FIFOSYNC_FWFT_EN
        exp_rd = (mq.size() != 0) ? mq[0] : 16'h0;
`else
        exp_rd = last_rd;
`endif
        check({tag, ".count"},        32'(count),        32'(mcount));
        check({tag, ".full"},         32'(full),         32'(mcount == 4));
        check({tag, ".empty"},        32'(empty),        32'(mcount == 0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(mcount >= 3));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(mcount <= 1));
        check({tag, ".overflow"},     32'(overflow),     32'(movf));
        check({tag, ".underflow"},    32'(underflow),    32'(mudf));
        check({tag, ".rd_data"},      32'(rd_data),      32'(exp_rd));
    endtask

    // One clock with the given request; the model updates after the edge, then everything is compared.
    task automatic cyc(input string tag, input logic w, input logic [15:0] d, input logic r);
        bit wacc;
        bit racc;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        wacc = w && (mcount != 4);
        racc = r && (mcount != 0);
        if (w && mcount == 4) movf = 1'b1;
        if (r && mcount == 0) mudf = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (racc) begin
            last_rd = mq.pop_front();
            mcount--;
        end
        if (wacc) begin
            mq.push_back(d);
            mcount++;
        end
        chk_state(tag);
    endtask

    task automatic do_reset(input string tag, input logic req);
        rst_n   = 1'b0;
        wr_en   = req;
        rd_en   = req;
        wr_data = 16'hBAD0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mq.delete();
        mcount  = 0;
        movf    = 1'b0;
        mudf    = 1'b0;
        last_rd = 16'h0;
        chk_state(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 16'h0;

        do_reset("rst0", 1'b0);
        do_reset("rst1", 1'b0);

        for (int i = 1; i <= 4; i++) cyc("fill", 1'b1, 16'(i) * 16'h1111, 1'b0);
        repeat (4) cyc("drain", 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 3; i++) cyc("thr_w", 1'b1, 16'h0100 + 16'(i), 1'b0);
        repeat (3) cyc("thr_r", 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 4; i++) cyc("ovf_fill", 1'b1, 16'h5000 + 16'(i), 1'b0);
        cyc("ovf", 1'b1, 16'hDEAD, 1'b0);
        cyc("ovf_sticky", 1'b0, 16'h0, 1'b0);
        cyc("ovf_rdwr", 1'b1, 16'hBEEF, 1'b1);
        repeat (3) cyc("ovf_drain", 1'b0, 16'h0, 1'b1);

        cyc("udf", 1'b1, 16'h00AA, 1'b1);
        cyc("simul", 1'b1, 16'h00BB, 1'b1);
        cyc("udf_drain", 1'b0, 16'h0, 1'b1);
        cyc("udf_sticky", 1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc("wrap_w", 1'b1, 16'(i), 1'b0);
            cyc("wrap_r", 1'b0, 16'h0, 1'b1);
        end

        cyc("mid_w", 1'b1, 16'h7001, 1'b0);
        cyc("mid_w", 1'b1, 16'h7002, 1'b0);
        do_reset("midrst", 1'b1);
        cyc("post_idle", 1'b0, 16'h0, 1'b0);
        cyc("post_w", 1'b1, 16'h7777, 1'b0);
        cyc("post_r", 1'b0, 16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fifosync.md
FIFOSYNC -- requirements
Module: fifosync

Interface
REQ-001 Parameter DW, default 16, data width in bits, legal range 1 or more.
REQ-002 Parameter AW, default 4, address width; DEPTH = 1<<AW entries; legal range 1 or more.
REQ-003 Parameter AFULL, default (1<<AW)-1, almost-full threshold in entries; legal range 1..DEPTH.
REQ-004 Parameter AEMPTY, default 1, almost-empty threshold in entries; legal range 0..DEPTH-1.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DW  write data.
REQ-009 rd_en  input  1  read (pop) request.
REQ-010 rd_data  output  DW  read data.
REQ-011 full, empty  output  1 each  occupancy == DEPTH, occupancy == 0.
REQ-012 almost_full, almost_empty  output  1 each  count >= AFULL, count <= AEMPTY.
REQ-013 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-014 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage SHALL be a DEPTH x DW array indexed by the low AW bits of (AW+1)-bit binary write and read pointers that wrap modulo 2*DEPTH.
REQ-016 A write SHALL be accepted iff wr_en=1 and full=0: the entry is stored at wr_ptr and wr_ptr increments.
REQ-017 A read SHALL be accepted iff rd_en=1 and empty=0: rd_ptr increments.
REQ-018 count SHALL be a register: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-019 full, empty, almost_full and almost_empty SHALL be decoded from registered state only, with no combinational path from wr_en or rd_en.
REQ-020 When wr_en=1 and full=1, the write SHALL be dropped and overflow SHALL set to 1 the next cycle, even if a read is accepted in the same cycle.
REQ-021 When rd_en=1 and empty=1, underflow SHALL set to 1 the next cycle; a write in the same cycle SHALL still be accepted.
REQ-022 overflow and underflow SHALL stay at 1 until reset.
REQ-023 A simultaneous accepted read and write when non-empty and non-full SHALL keep count constant and preserve FIFO order.
REQ-024 Standard mode (macro undefined): on an accepted read, rd_data SHALL present the head entry one cycle later.
REQ-025 Standard mode: rd_data SHALL hold its value when no read is accepted.
REQ-026 Pointer wrap SHALL be seamless: data order is preserved across any number of wraps.

Reset
REQ-027 While rst_n=0 at a clk edge, reset SHALL override wr_en and rd_en.
REQ-028 Reset SHALL set both pointers and count to 0.
REQ-029 After reset, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_data=0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries within one cycle.

Configuration
REQ-032 Macro FIFOSYNC_FWFT_EN SHALL select first-word-fall-through mode.
REQ-033 With FIFOSYNC_FWFT_EN defined, rd_data SHALL show the head entry combinationally from storage whenever empty=0, and 0 when empty=1.
REQ-034 With FIFOSYNC_FWFT_EN defined, rd_en SHALL pop the entry shown in the same cycle.
REQ-035 Without FIFOSYNC_FWFT_EN, the standard-mode behaviour of REQ-024 and REQ-025 SHALL apply.
REQ-036 All flags and counters SHALL behave identically in both modes.

Verification (DW=16, AW=2, DEPTH=4, AFULL=3, AEMPTY=1)
REQ-037 Fill and drain: write 0x1111..0x4444 on 4 consecutive cycles, then read 4 -> full=1 and count=4 after the 4th write; reads return 0x1111..0x4444 in order; empty=1 at the end.
REQ-038 Thresholds: write 3 entries -> almost_full=1 at count=3 and almost_empty=0 at count=2; read 2 entries -> almost_empty=1 at count=1.
REQ-039 Overflow: with the FIFO full, wr_en with 0xDEAD -> count stays 4, overflow=1 and sticky; 0xDEAD is never read out.
REQ-040 Underflow and simultaneous: rd_en+wr_en 0x00AA while empty -> underflow=1, count=1; next cycle rd_en+wr_en 0x00BB -> count=1, read returns 0x00AA.
REQ-041 Wrap: 10 write/read pairs of 0x0000..0x0009 -> data returned in order, count never exceeds 1.
REQ-042 Mid-run reset: rst_n=0 for one cycle with count=2 -> count=0, empty=1, flags cleared, rd_data=0; in FWFT mode rd_data=0 while empty.
